// File: rtl/snake_body_engine.sv
// Snake body state engine: segment storage, per-tick stepping, growth,
// wall/self collision detection and a registered cell-occupancy query.
module snake_body_engine #(
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48,
  parameter int COORD_W  = 6,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int WRAP     = 0,
  parameter int START_X  = 32,
  parameter int START_Y  = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick_i,
  input  logic                         restart_i,
  input  logic                         dir_valid_i,
  input  logic [1:0]                   dir_i,
  input  logic                         grow_i,
  input  logic [COORD_W-1:0]           query_x_i,
  input  logic [COORD_W-1:0]           query_y_i,
  output logic                         query_hit_o,
  output logic                         query_head_o,
  output logic [COORD_W-1:0]           head_x_o,
  output logic [COORD_W-1:0]           head_y_o,
  output logic [$clog2(MAX_LEN+1)-1:0] length_o,
  output logic                         alive_o,
  output logic                         step_done_o
);

  localparam int LW  = $clog2(MAX_LEN + 1);
  localparam int CW1 = COORD_W + 1;

  localparam logic [CW1-1:0] X_MAX  = CW1'(GRID_W - 1);
  localparam logic [CW1-1:0] Y_MAX  = CW1'(GRID_H - 1);
  localparam logic [CW1-1:0] C_ONE  = CW1'(1);
  localparam logic [LW-1:0]  L_ONE  = LW'(1);
  localparam logic [LW-1:0]  L_MAX  = LW'(MAX_LEN);
  localparam logic [LW-1:0]  L_INIT = LW'(INIT_LEN);

  typedef enum logic {ST_RUN, ST_DEAD} state_t;
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  state_t             state_q, state_d;
  dir_t               pend_q, pend_d;
  dir_t               cmt_q, cmt_d;
  logic               grow_q, grow_d;
  logic               step_q, step_d;
  logic               done_q, done_d;
  logic               qhit_q, qhit_d;
  logic               qhead_q, qhead_d;
  logic [LW-1:0]      len_q, len_d;
  logic [COORD_W-1:0] segx_q [MAX_LEN];
  logic [COORD_W-1:0] segx_d [MAX_LEN];
  logic [COORD_W-1:0] segy_q [MAX_LEN];
  logic [COORD_W-1:0] segy_d [MAX_LEN];

  logic [CW1-1:0]     nx, ny;
  logic [COORD_W-1:0] new_x, new_y;
  logic               wall, self_hit, collide, grow_now;
  logic [LW-1:0]      body_lim;
  logic               running, exec;

  function automatic logic [COORD_W-1:0] init_x(int unsigned i);
    return (int'(i) < INIT_LEN) ? COORD_W'(START_X - int'(i)) : '0;
  endfunction

  function automatic logic [COORD_W-1:0] init_y(int unsigned i);
    return (int'(i) < INIT_LEN) ? COORD_W'(START_Y) : '0;
  endfunction

  // Candidate head from the committed direction, edge handling and collision test.
  always_comb begin
    nx = {1'b0, segx_q[0]};
    ny = {1'b0, segy_q[0]};
    unique case (cmt_q)
      DIR_UP:    ny = ny - C_ONE;
      DIR_RIGHT: nx = nx + C_ONE;
      DIR_DOWN:  ny = ny + C_ONE;
      default:   nx = nx - C_ONE;
    endcase
    // Only one axis moves, so an out-of-range value identifies the crossing edge.
    wall = 1'b0;
    if (nx > X_MAX) begin
      if (WRAP != 0) nx = (cmt_q == DIR_LEFT) ? X_MAX : '0;
      else           wall = 1'b1;
    end
    if (ny > Y_MAX) begin
      if (WRAP != 0) ny = (cmt_q == DIR_UP) ? Y_MAX : '0;
      else           wall = 1'b1;
    end
    new_x = nx[COORD_W-1:0];
    new_y = ny[COORD_W-1:0];
    grow_now = grow_q && (len_q < L_MAX);
    // The tail cell vacates on a non-growing step, so it is excluded from the test.
    body_lim = grow_now ? len_q : len_q - L_ONE;
    self_hit = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < body_lim) && (segx_q[i] == new_x) && (segy_q[i] == new_y))
        self_hit = 1'b1;
    end
    collide = wall || self_hit;
  end

  // Next-state logic: restart, tick pipeline, direction filter, grow flag, body shift, query.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cmt_d   = cmt_q;
    grow_d  = grow_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    qhit_d  = 1'b0;
    qhead_d = 1'b0;
    len_d   = len_q;
    segx_d  = segx_q;
    segy_d  = segy_q;
    running = (state_q == ST_RUN);
    exec    = step_q && running;

    if (restart_i) begin
      state_d = ST_RUN;
      pend_d  = DIR_RIGHT;
      cmt_d   = DIR_RIGHT;
      grow_d  = 1'b0;
      len_d   = L_INIT;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        segx_d[i] = init_x(i);
        segy_d[i] = init_y(i);
      end
    end else begin
      // Commit at the sampling edge; the move itself lands one edge later.
      if (running && tick_i) begin
        step_d = 1'b1;
        cmt_d  = pend_q;
      end
      if (running && dir_valid_i && (dir_i != (cmt_q ^ 2'b10)))
        pend_d = dir_t'(dir_i);
      if (exec) begin
        done_d = 1'b1;
        grow_d = 1'b0;
        if (collide) begin
          state_d = ST_DEAD;
        end else begin
          for (int unsigned i = 1; i < MAX_LEN; i++) begin
            segx_d[i] = segx_q[i-1];
            segy_d[i] = segy_q[i-1];
          end
          segx_d[0] = new_x;
          segy_d[0] = new_y;
          if (grow_now) len_d = len_q + L_ONE;
        end
      end
      if (running && grow_i && !(exec && collide))
        grow_d = 1'b1;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        if ((LW'(i) < len_q) && (segx_q[i] == query_x_i) && (segy_q[i] == query_y_i))
          qhit_d = 1'b1;
      end
      qhead_d = (segx_q[0] == query_x_i) && (segy_q[0] == query_y_i);
    end
  end

  // State register with asynchronous reset to the initial body.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pend_q  <= DIR_RIGHT;
      cmt_q   <= DIR_RIGHT;
      grow_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      qhit_q  <= 1'b0;
      qhead_q <= 1'b0;
      len_q   <= L_INIT;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        segx_q[i] <= init_x(i);
        segy_q[i] <= init_y(i);
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cmt_q   <= cmt_d;
      grow_q  <= grow_d;
      step_q  <= step_d;
      done_q  <= done_d;
      qhit_q  <= qhit_d;
      qhead_q <= qhead_d;
      len_q   <= len_d;
      segx_q  <= segx_d;
      segy_q  <= segy_d;
    end
  end

  assign head_x_o     = segx_q[0];
  assign head_y_o     = segy_q[0];
  assign length_o     = len_q;
  assign alive_o      = (state_q == ST_RUN);
  assign step_done_o  = done_q;
  assign query_hit_o  = qhit_q;
  assign query_head_o = qhead_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: three configurations (edges kill, edges wrap,
// MAX_LEN=5) share one stimulus stream; directed scenarios plus a random run
// against a coordinate-list model of the game rules.
module tb_snake_body_engine;

  localparam logic [1:0] UP = 2'd0, RT = 2'd1, DN = 2'd2, LT = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, restart = 1'b0, dir_valid = 1'b0, grow = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [5:0] qx = '0, qy = '0;

  logic [5:0] hx [3];
  logic [5:0] hy [3];
  logic       qhit [3];
  logic       qhead [3];
  logic       alive [3];
  logic       done [3];
  logic [4:0] len0, len1;
  logic [2:0] len2;
  int         olen [3];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, one entry per configuration.
  int ML [3] = '{16, 16, 5};
  int WR [3] = '{0, 1, 0};
  int DX [4] = '{0, 1, 0, -1};
  int DY [4] = '{-1, 0, 1, 0};
  int m_bx [3][16];
  int m_by [3][16];
  int m_len [3];
  int m_pend [3];
  int m_cmt [3];
  bit m_alive [3];
  bit m_grow [3];
  bit m_step [3];
  bit m_done [3];
  bit m_qhit [3];
  bit m_qhead [3];

  always #5 clk = ~clk;

  always_comb begin
    olen[0] = int'(len0);
    olen[1] = int'(len1);
    olen[2] = int'(len2);
  end

  snake_body_engine dut0 (
    .clk(clk), .rst(rst), .tick_i(tick), .restart_i(restart), .dir_valid_i(dir_valid),
    .dir_i(dir), .grow_i(grow), .query_x_i(qx), .query_y_i(qy),
    .query_hit_o(qhit[0]), .query_head_o(qhead[0]), .head_x_o(hx[0]), .head_y_o(hy[0]),
    .length_o(len0), .alive_o(alive[0]), .step_done_o(done[0]));

  snake_body_engine #(.WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .tick_i(tick), .restart_i(restart), .dir_valid_i(dir_valid),
    .dir_i(dir), .grow_i(grow), .query_x_i(qx), .query_y_i(qy),
    .query_hit_o(qhit[1]), .query_head_o(qhead[1]), .head_x_o(hx[1]), .head_y_o(hy[1]),
    .length_o(len1), .alive_o(alive[1]), .step_done_o(done[1]));

  snake_body_engine #(.MAX_LEN(5)) dut2 (
    .clk(clk), .rst(rst), .tick_i(tick), .restart_i(restart), .dir_valid_i(dir_valid),
    .dir_i(dir), .grow_i(grow), .query_x_i(qx), .query_y_i(qy),
    .query_hit_o(qhit[2]), .query_head_o(qhead[2]), .head_x_o(hx[2]), .head_y_o(hy[2]),
    .length_o(len2), .alive_o(alive[2]), .step_done_o(done[2]));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick = 1'b0; restart = 1'b0; dir_valid = 1'b0; grow = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1; cyc(); restart = 1'b0;
  endtask

  // Optional direction request in its own cycle, then tick (+grow), then wait for the step.
  task automatic step(input logic [1:0] d, input logic with_dir, input logic g);
    if (with_dir) begin dir_valid = 1'b1; dir = d; cyc(); dir_valid = 1'b0; end
    tick = 1'b1; grow = g; cyc(); tick = 1'b0; grow = 1'b0; cyc();
  endtask

  // Game rules applied at one clock edge, using the inputs held across that edge.
  function automatic void model_edge(int c);
    bit run, ex, coll, growing;
    int nx, ny, lim, newp;
    if (restart) begin
      for (int i = 0; i < 16; i++) begin
        m_bx[c][i] = (i < 4) ? 32 - i : 0;
        m_by[c][i] = (i < 4) ? 24 : 0;
      end
      m_len[c] = 4; m_alive[c] = 1; m_grow[c] = 0; m_step[c] = 0; m_done[c] = 0;
      m_pend[c] = 1; m_cmt[c] = 1; m_qhit[c] = 0; m_qhead[c] = 0;
      return;
    end
    run = m_alive[c];
    m_qhit[c] = 0;
    for (int i = 0; i < m_len[c]; i++)
      if (m_bx[c][i] == int'(qx) && m_by[c][i] == int'(qy)) m_qhit[c] = 1;
    m_qhead[c] = (m_bx[c][0] == int'(qx)) && (m_by[c][0] == int'(qy));
    ex = m_step[c] && run;
    coll = 0;
    if (ex) begin
      nx = m_bx[c][0] + DX[m_cmt[c]];
      ny = m_by[c][0] + DY[m_cmt[c]];
      if (nx < 0 || nx >= 64 || ny < 0 || ny >= 48) begin
        if (WR[c] != 0) begin nx = (nx + 64) % 64; ny = (ny + 48) % 48; end
        else coll = 1;
      end
      growing = m_grow[c] && (m_len[c] < ML[c]);
      lim = growing ? m_len[c] : m_len[c] - 1;
      for (int i = 0; i < lim; i++)
        if (m_bx[c][i] == nx && m_by[c][i] == ny) coll = 1;
      if (coll) m_alive[c] = 0;
      else begin
        for (int i = 15; i > 0; i--) begin
          m_bx[c][i] = m_bx[c][i-1];
          m_by[c][i] = m_by[c][i-1];
        end
        m_bx[c][0] = nx; m_by[c][0] = ny;
        if (growing) m_len[c]++;
      end
      m_grow[c] = 0;
    end
    m_done[c] = ex;
    if (run && grow && !coll) m_grow[c] = 1;
    newp = m_pend[c];
    if (run && dir_valid && int'(dir) != (m_cmt[c] + 2) % 4) newp = int'(dir);
    if (run && tick) m_cmt[c] = m_pend[c];
    m_pend[c] = newp;
    m_step[c] = run && tick;
  endfunction

  task automatic test_reset();
    idle(); rst = 1'b1; cyc(); cyc();
    for (int d = 0; d < 3; d++) begin
      vectors++; if (hx[d] !== 6'd32) begin miscompares++; $display("FAIL reset_hx dut%0d got %0d want 32", d, hx[d]); end
      vectors++; if (hy[d] !== 6'd24) begin miscompares++; $display("FAIL reset_hy dut%0d got %0d want 24", d, hy[d]); end
      vectors++; if (olen[d] != 4) begin miscompares++; $display("FAIL reset_len dut%0d got %0d want 4", d, olen[d]); end
      vectors++; if (alive[d] !== 1'b1) begin miscompares++; $display("FAIL reset_alive dut%0d got %b want 1", d, alive[d]); end
      vectors++; if (done[d] !== 1'b0 || qhit[d] !== 1'b0 || qhead[d] !== 1'b0) begin miscompares++; $display("FAIL reset_flags dut%0d got done=%b hit=%b head=%b want 0/0/0", d, done[d], qhit[d], qhead[d]); end
    end
    rst = 1'b0; cyc();
    // A reset landing between tick sampling and the move cancels the step.
    tick = 1'b1; cyc(); tick = 1'b0; #2; rst = 1'b1; cyc(); rst = 1'b0; cyc(); cyc();
    for (int d = 0; d < 3; d++) begin
      vectors++; if (hx[d] !== 6'd32 || done[d] !== 1'b0) begin miscompares++; $display("FAIL reset_abort dut%0d got hx=%0d done=%b want hx=32 done=0", d, hx[d], done[d]); end
    end
  endtask

  task automatic test_ticks();
    int pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      if (done[0] === 1'b1) pulses++;
      vectors++; if (hx[0] !== 6'(32 + k)) begin miscompares++; $display("FAIL tick_latency got %0d want %0d", hx[0], 32 + k); end
      cyc(); if (done[0] === 1'b1) pulses++;
      cyc(); if (done[0] === 1'b1) pulses++;
    end
    vectors++; if (pulses != 3) begin miscompares++; $display("FAIL step_done_pulses got %0d want 3", pulses); end
    for (int d = 0; d < 3; d++) begin
      vectors++; if (hx[d] !== 6'd35 || hy[d] !== 6'd24 || olen[d] != 4) begin miscompares++; $display("FAIL ticks_head dut%0d got (%0d,%0d) len %0d want (35,24) len 4", d, hx[d], hy[d], olen[d]); end
    end
    qx = 6'd32; qy = 6'd24; cyc();
    for (int d = 0; d < 3; d++) begin
      vectors++; if (qhit[d] !== 1'b1 || qhead[d] !== 1'b0) begin miscompares++; $display("FAIL query_body dut%0d got hit=%b head=%b want 1/0", d, qhit[d], qhead[d]); end
    end
    qx = 6'd31; cyc();
    vectors++; if (qhit[0] !== 1'b0) begin miscompares++; $display("FAIL query_past_tail got %b want 0", qhit[0]); end
    qx = 6'd35; cyc();
    vectors++; if (qhit[0] !== 1'b1 || qhead[0] !== 1'b1) begin miscompares++; $display("FAIL query_head got hit=%b head=%b want 1/1", qhit[0], qhead[0]); end
  endtask

  task automatic test_dir_filter();
    step(LT, 1'b1, 1'b0);
    vectors++; if (hx[0] !== 6'd36 || hy[0] !== 6'd24) begin miscompares++; $display("FAIL reverse_dropped got (%0d,%0d) want (36,24)", hx[0], hy[0]); end
    dir_valid = 1'b1; dir = UP; cyc(); dir = LT; cyc(); dir_valid = 1'b0;
    step(UP, 1'b0, 1'b0);
    vectors++; if (hx[0] !== 6'd36 || hy[0] !== 6'd23) begin miscompares++; $display("FAIL up_then_left got (%0d,%0d) want (36,23)", hx[0], hy[0]); end
    dir_valid = 1'b1; dir = RT; tick = 1'b1; cyc(); dir_valid = 1'b0; tick = 1'b0; cyc();
    vectors++; if (hx[0] !== 6'd36 || hy[0] !== 6'd22) begin miscompares++; $display("FAIL dir_with_tick got (%0d,%0d) want (36,22)", hx[0], hy[0]); end
    step(UP, 1'b0, 1'b0);
    vectors++; if (hx[0] !== 6'd37 || hy[0] !== 6'd22) begin miscompares++; $display("FAIL dir_next_step got (%0d,%0d) want (37,22)", hx[0], hy[0]); end
  endtask

  task automatic test_wall();
    do_restart();
    tick = 1'b1; repeat (31) cyc(); tick = 1'b0; cyc();
    for (int d = 0; d < 3; d++) begin
      vectors++; if (hx[d] !== 6'd63 || alive[d] !== 1'b1) begin miscompares++; $display("FAIL edge_reach dut%0d got x=%0d alive=%b want 63/1", d, hx[d], alive[d]); end
    end
    step(RT, 1'b0, 1'b0);
    for (int d = 0; d < 3; d += 2) begin
      vectors++; if (hx[d] !== 6'd63 || alive[d] !== 1'b0 || done[d] !== 1'b1) begin miscompares++; $display("FAIL wall_kill dut%0d got x=%0d alive=%b done=%b want 63/0/1", d, hx[d], alive[d], done[d]); end
    end
    vectors++; if (hx[1] !== 6'd0 || hy[1] !== 6'd24 || alive[1] !== 1'b1) begin miscompares++; $display("FAIL wrap_x got (%0d,%0d) alive=%b want (0,24)/1", hx[1], hy[1], alive[1]); end
    for (int k = 0; k < 3; k++) begin
      step(UP, 1'b1, 1'b1);
      vectors++; if (hx[0] !== 6'd63 || hy[0] !== 6'd24 || olen[0] != 4 || done[0] !== 1'b0) begin miscompares++; $display("FAIL dead_frozen got (%0d,%0d) len %0d done=%b want (63,24) len 4 done 0", hx[0], hy[0], olen[0], done[0]); end
    end
    do_restart();
    for (int d = 0; d < 3; d++) begin
      vectors++; if (hx[d] !== 6'd32 || hy[d] !== 6'd24 || alive[d] !== 1'b1 || olen[d] != 4) begin miscompares++; $display("FAIL restart dut%0d got (%0d,%0d) alive=%b len %0d want (32,24)/1/4", d, hx[d], hy[d], alive[d], olen[d]); end
    end
  endtask

  task automatic test_wrap();
    dir_valid = 1'b1; dir = UP; cyc(); dir_valid = 1'b0;
    tick = 1'b1; repeat (25) cyc(); tick = 1'b0; cyc();
    vectors++; if (hx[1] !== 6'd32 || hy[1] !== 6'd47 || alive[1] !== 1'b1) begin miscompares++; $display("FAIL wrap_y got (%0d,%0d) alive=%b want (32,47)/1", hx[1], hy[1], alive[1]); end
    vectors++; if (hy[0] !== 6'd0 || alive[0] !== 1'b0) begin miscompares++; $display("FAIL top_wall got y=%0d alive=%b want 0/0", hy[0], alive[0]); end
    do_restart();
  endtask

  task automatic test_grow_self();
    step(RT, 1'b0, 1'b1);
    for (int d = 0; d < 3; d++) begin
      vectors++; if (olen[d] != 5 || hx[d] !== 6'd33) begin miscompares++; $display("FAIL grow_once dut%0d got len %0d x=%0d want 5/33", d, olen[d], hx[d]); end
    end
    step(UP, 1'b1, 1'b0); step(LT, 1'b1, 1'b0); step(DN, 1'b1, 1'b0);
    for (int d = 0; d < 3; d++) begin
      vectors++; if (alive[d] !== 1'b0 || olen[d] != 5 || hx[d] !== 6'd32 || hy[d] !== 6'd23 || done[d] !== 1'b1) begin miscompares++; $display("FAIL self_hit dut%0d got alive=%b len %0d (%0d,%0d) done=%b want 0/5/(32,23)/1", d, alive[d], olen[d], hx[d], hy[d], done[d]); end
    end
    do_restart();
  endtask

  task automatic test_maxlen();
    logic [1:0] loop_dir [4] = '{UP, LT, DN, RT};
    int loop_x [4] = '{32, 31, 31, 32};
    int loop_y [4] = '{23, 23, 24, 24};
    for (int k = 0; k < 3; k++) begin
      step(RT, 1'b0, 1'b1);
      vectors++; if (olen[0] != 5 + k || olen[2] != 5) begin miscompares++; $display("FAIL grow_sat step%0d got len %0d/%0d want %0d/5", k, olen[0], olen[2], 5 + k); end
    end
    step(RT, 1'b0, 1'b0);
    vectors++; if (olen[0] != 7 || olen[2] != 5 || alive[2] !== 1'b1) begin miscompares++; $display("FAIL grow_flag_cleared got len %0d/%0d alive=%b want 7/5/1", olen[0], olen[2], alive[2]); end
    do_restart();
    for (int k = 0; k < 8; k++) begin
      step(loop_dir[k % 4], 1'b1, 1'b0);
      for (int d = 0; d < 3; d++) begin
        vectors++; if (alive[d] !== 1'b1 || hx[d] !== 6'(loop_x[k % 4]) || hy[d] !== 6'(loop_y[k % 4])) begin miscompares++; $display("FAIL tail_follow step%0d dut%0d got (%0d,%0d) alive=%b want (%0d,%0d)/1", k, d, hx[d], hy[d], alive[d], loop_x[k % 4], loop_y[k % 4]); end
      end
    end
    do_restart();
  endtask

  task automatic test_random();
    int prints = 0;
    bit any_dead;
    int j;
    for (int k = 0; k < 3000; k++) begin
      any_dead = !m_alive[0] || !m_alive[1] || !m_alive[2];
      tick      = ($urandom_range(0, 2) != 0);
      dir_valid = ($urandom_range(0, 3) == 0);
      dir       = 2'($urandom_range(0, 3));
      grow      = ($urandom_range(0, 7) == 0);
      restart   = (k == 0) || ($urandom_range(0, any_dead ? 7 : 299) == 0);
      if ($urandom_range(0, 1) == 0 && m_len[0] > 0) begin
        j = $urandom_range(0, m_len[0] - 1);
        qx = 6'(m_bx[0][j]); qy = 6'(m_by[0][j]);
      end else begin
        qx = 6'($urandom_range(0, 63)); qy = 6'($urandom_range(0, 63));
      end
      cyc();
      for (int c = 0; c < 3; c++) model_edge(c);
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (hx[d] !== 6'(m_bx[d][0]) || hy[d] !== 6'(m_by[d][0]) || olen[d] != m_len[d] ||
            alive[d] !== m_alive[d] || done[d] !== m_done[d] || qhit[d] !== m_qhit[d] || qhead[d] !== m_qhead[d]) begin
          miscompares++;
          if (prints < 30) begin
            prints++;
            $display("FAIL random cyc%0d dut%0d got (%0d,%0d) len %0d alive %b done %b hit %b head %b want (%0d,%0d) len %0d alive %b done %b hit %b head %b",
                     k, d, hx[d], hy[d], olen[d], alive[d], done[d], qhit[d], qhead[d],
                     m_bx[d][0], m_by[d][0], m_len[d], m_alive[d], m_done[d], m_qhit[d], m_qhead[d]);
          end
        end
      end
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ticks();
    test_dir_filter();
    test_wall();
    test_wrap();
    test_grow_self();
    test_maxlen();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
